// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller state encodings, ISA opcodes and ALU selects.
// The controller and the instruction decoder both import this package.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode and operand field extraction from the held instruction.
// Opcodes outside the defined set fall through to NOOP (all flags low).
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] IR,
  output logic        is_store,
  output logic        is_load,
  output logic        is_add,
  output logic        is_sub,
  output logic        is_halt,
  output logic [7:0]  mem_addr,
  output logic [3:0]  reg_a,
  output logic [3:0]  reg_b,
  output logic [3:0]  reg_d
);

  always_comb begin
    is_store = 1'b0;
    is_load  = 1'b0;
    is_add   = 1'b0;
    is_sub   = 1'b0;
    is_halt  = 1'b0;
    case (IR[15:12])
      OP_STORE: is_store = 1'b1;
      OP_LOAD:  is_load  = 1'b1;
      OP_ADD:   is_add   = 1'b1;
      OP_SUB:   is_sub   = 1'b1;
      OP_HALT:  is_halt  = 1'b1;
      default:  ;
    endcase
  end

  // Low nibble is Ra for STORE and Rd for LOAD/ADD/SUB; the top level picks the role.
  assign mem_addr = IR[11:4];
  assign reg_a    = IR[11:8];
  assign reg_b    = IR[7:4];
  assign reg_d    = IR[3:0];

endmodule

// File: rtl/control_fsm.sv
// Moore fetch/decode/execute sequencer driving the PC, IR, data memory, register file and ALU.
// Outputs depend only on the state register and the held IR, so reset drops write strobes at once.
module control_fsm
  import cpu_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  State
);

  state_t     state;
  logic       is_store;
  logic       is_load;
  logic       is_add;
  logic       is_sub;
  logic       is_halt;
  logic [7:0] mem_addr;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] reg_d;

  instr_decode u_decode (
    .IR       (IR),
    .is_store (is_store),
    .is_load  (is_load),
    .is_add   (is_add),
    .is_sub   (is_sub),
    .is_halt  (is_halt),
    .mem_addr (mem_addr),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .reg_d    (reg_d)
  );

  // Any encoding outside the enum lands in default and restarts from INIT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_INIT;
    end else begin
      case (state)
        ST_INIT:   state <= ST_FETCH;
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          if (is_load)
            state <= ST_LOAD_A;
          else if (is_store)
            state <= ST_STORE;
          else if (is_add)
            state <= ST_ADD;
          else if (is_sub)
            state <= ST_SUB;
          else if (is_halt)
            state <= ST_HALT;
          else
            state <= ST_NOOP;
        end
        ST_LOAD_A: state <= ST_LOAD_B;
        ST_LOAD_B: state <= ST_FETCH;
        ST_NOOP:   state <= ST_FETCH;
        ST_STORE:  state <= ST_FETCH;
        ST_ADD:    state <= ST_FETCH;
        ST_SUB:    state <= ST_FETCH;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALU_s0     = ALU_PASS;
    case (state)
      ST_INIT: PC_clr = 1'b1;
      ST_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      ST_LOAD_A, ST_LOAD_B: begin
        D_addr    = mem_addr;
        RF_s      = 1'b1;
        RF_W_addr = reg_d;
        RF_W_en   = (state == ST_LOAD_B);
      end
      ST_STORE: begin
        D_addr     = mem_addr;
        D_wr       = 1'b1;
        RF_Ra_addr = reg_d;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_addr = reg_a;
        RF_Rb_addr = reg_b;
        RF_W_addr  = reg_d;
        RF_W_en    = 1'b1;
        ALU_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed ISA cases, random instruction stream,
// HALT parking and asynchronous reset, compared against a per-instruction state-sequence model.
module tb_control_fsm;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] IR;
  logic        PC_clr;
  logic        PC_up;
  logic        IR_ld;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra;
    logic [3:0] rf_rb;
    logic [2:0] alu;
    logic [3:0] state;
  } outs_t;

  int checks = 0;
  int errors = 0;

  control_fsm dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .State      (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected output vector for a displayed state number holding instruction ir.
  function automatic outs_t expected_outs(input int st, input logic [15:0] ir);
    outs_t e;
    e = '0;
    e.state = 4'(st);
    case (st)
      0: e.pc_clr = 1'b1;
      1: begin e.ir_ld = 1'b1; e.pc_up = 1'b1; end
      4, 5: begin
        e.d_addr    = ir[11:4];
        e.rf_s      = 1'b1;
        e.rf_w_addr = ir[3:0];
        e.rf_w_en   = (st == 5);
      end
      6: begin e.d_addr = ir[11:4]; e.d_wr = 1'b1; e.rf_ra = ir[3:0]; end
      7, 8: begin
        e.rf_ra     = ir[11:8];
        e.rf_rb     = ir[7:4];
        e.rf_w_addr = ir[3:0];
        e.rf_w_en   = 1'b1;
        e.alu       = (st == 7) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input int st, input string tag);
    outs_t obs;
    outs_t exp_v;
    obs = {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, State};
    exp_v = expected_outs(st, IR);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h (IR=%h)", tag, obs, exp_v, IR);
    end
  endtask

  // Runs one instruction from FETCH; optionally aborts with reset in the final LOAD_B cycle.
  task automatic applyStimulus(input logic [15:0] instr, input string tag, input bit abort_in_load_b);
    int seq[$];
    seq = {1, 2};
    case (instr[15:12])
      4'd1: seq.push_back(6);
      4'd2: begin seq.push_back(4); seq.push_back(5); end
      4'd3: seq.push_back(7);
      4'd4: seq.push_back(8);
      4'd5: seq.push_back(9);
      default: seq.push_back(3);
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge Clk);
      #1;
      if (i == 1) IR = instr;
      @(negedge Clk);
      checkOutput(seq[i], tag);
    end
    if (abort_in_load_b) begin
      #2 Reset_n = 1'b0;
      #1;
      checkOutput(0, {tag, "_abort"});
      checks++;
      assert (RF_W_en === 1'b0) else begin
        errors++;
        $error("[TB] FAIL %s_wen_drop: observed %b expected 0", tag, RF_W_en);
      end
      @(negedge Clk);
      checkOutput(0, {tag, "_held"});
      Reset_n = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] r;
    Reset_n = 1'b0;
    IR      = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput(0, "reset_hold");
    end
    Reset_n = 1'b1;
    #1 checkOutput(0, "reset_release");

    applyStimulus(16'h21B5, "load", 1'b0);
    applyStimulus(16'h3123, "add", 1'b0);
    applyStimulus(16'h4123, "sub", 1'b0);
    applyStimulus(16'h1A47, "store", 1'b0);
    applyStimulus(16'hF000, "illegal_op", 1'b0);
    applyStimulus(16'h0ABC, "noop", 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = 16'($urandom);
      if (r[15:12] == 4'd5) r[15:12] = 4'd2;
      applyStimulus(r, "random", 1'b0);
    end

    applyStimulus(16'h2C3E, "load_abort", 1'b1);
    applyStimulus(16'h3456, "after_abort", 1'b0);

    applyStimulus(16'h5000, "halt", 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk);
      #1 IR = 16'($urandom);
      @(negedge Clk);
      checkOutput(9, "halt_park");
    end
    #2 Reset_n = 1'b0;
    #1 checkOutput(0, "halt_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(16'h1FF0, "after_halt", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
